// File: rtl/mux_scan_if.sv
// Mux select/return path plus the downstream valid/ready sample channel.
interface mux_scan_if #(
  parameter int unsigned WIDTH = 4
);
  logic [2:0]       sel;
  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_ch;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output sel,
    input  mux_y,
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  sel,
    output mux_y,
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Sweeps enabled mux channels in ascending order, waits DWELL cycles per select,
// captures the mux output and offers {channel, data} on a valid/ready handshake.
module mux_scan_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic [7:0] en_mask,
  output logic       busy,
  output logic       sweep_done,
  mux_scan_if.master bus
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       sel_q, sel_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [7:0]       mask_q, mask_nxt;
  logic             cont_q, cont_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [2:0]       ch_q, ch_nxt;
  logic             valid_q, valid_nxt;
  logic             done_q, done_nxt;
  logic             busy_q, busy_nxt;
  logic [7:0]       higher;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  // Enabled channels above the current select in the latched mask
  always_comb begin
    higher = '0;
    for (int i = 0; i < 8; i++) begin
      higher[i] = mask_q[i] && (3'(i) > sel_q);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!stop && start && (en_mask != 8'd0)) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (stop)                state_nxt = IDLE;
        else if (cnt_q == '0)    state_nxt = HOLD;
      end
      HOLD: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (bus.out_ready) begin
          if (higher != 8'd0)                     state_nxt = SETTLE;
          else if (cont_q && (en_mask != 8'd0))   state_nxt = SETTLE;
          else                                    state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    sel_nxt   = sel_q;
    cnt_nxt   = cnt_q;
    mask_nxt  = mask_q;
    cont_nxt  = cont_q;
    data_nxt  = data_q;
    ch_nxt    = ch_q;
    valid_nxt = valid_q;
    done_nxt  = 1'b0;
    busy_nxt  = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (!stop && start && (en_mask != 8'd0)) begin
          mask_nxt = en_mask;
          cont_nxt = continuous;
          sel_nxt  = lowest_set(en_mask);
          cnt_nxt  = CW'(DWELL - 1);
        end
      end
      SETTLE: begin
        if (stop) begin
          valid_nxt = 1'b0;
        end else if (cnt_q == '0) begin
          data_nxt  = bus.mux_y;
          ch_nxt    = sel_q;
          valid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (stop) begin
          valid_nxt = 1'b0;
        end else if (bus.out_ready) begin
          valid_nxt = 1'b0;
          cnt_nxt   = CW'(DWELL - 1);
          if (higher != 8'd0) begin
            sel_nxt = lowest_set(higher);
          end else begin
            done_nxt = 1'b1;
            if (cont_q) begin
              mask_nxt = en_mask;
              if (en_mask != 8'd0) sel_nxt = lowest_set(en_mask);
            end
          end
        end
      end
      default: valid_nxt = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sel_q   <= sel_nxt;
      cnt_q   <= cnt_nxt;
      mask_q  <= mask_nxt;
      cont_q  <= cont_nxt;
      data_q  <= data_nxt;
      ch_q    <= ch_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;
  assign busy          = busy_q;
  assign sweep_done    = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: cycle table, directed corner cases,
// and randomized sweeps checked against a transaction-level sample model.
module tb_mux_scan_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DWELL = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, continuous;
  logic [7:0] en_mask;
  logic       busy, sweep_done;
  logic [3:0] lut [8];

  mux_scan_if #(.WIDTH(WIDTH)) mif ();

  assign mif.mux_y = lut[mif.sel];

  mux_scan_sequencer #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .en_mask    (en_mask),
    .busy       (busy),
    .sweep_done (sweep_done),
    .bus        (mif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [7:0] mask;
    logic       ready;
    logic       e_valid;
    logic [2:0] e_ch;
    logic [3:0] e_data;
    logic [2:0] e_sel;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t       tbl [14];
  int         n_vec = 0;
  int         n_bad = 0;
  logic       pv, rdy;
  logic [2:0] pch;
  logic [3:0] pdata;
  int         since, budget;
  logic [2:0] q_ch [$];
  bit         q_last [$];
  int         ev [$];
  int         exp3 [9];
  logic [7:0] m;
  bit         c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid_ch(input logic [2:0] ch, input string name);
    int n;
    n = 0;
    while (!(mif.out_valid && mif.out_ch == ch) && n < 50) begin
      step();
      n++;
    end
    chk(name, 32'(mif.out_valid && mif.out_ch == ch), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) lut[k] = 4'(k + 8);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    en_mask = 8'h00; mif.out_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(mif.out_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_sel",   32'(mif.sel), 32'd0);
    chk("rst_done",  32'(sweep_done), 32'd0);
    #9;
    rst_n = 1'b1;
    step();

    // Single sweep, mask A5, ready high, one row per edge
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 3'd0, 4'd0,  3'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd0, 4'd0,  3'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 3'd0, 4'd8,  3'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd0, 4'd8,  3'd2, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd0, 4'd8,  3'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 3'd2, 4'd10, 3'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd2, 4'd10, 3'd5, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd2, 4'd10, 3'd5, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 3'd5, 4'd13, 3'd5, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd5, 4'd13, 3'd7, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd5, 4'd13, 3'd7, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'hA5, 1'b1, 1'b1, 3'd7, 4'd15, 3'd7, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd7, 4'd15, 3'd7, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd7, 4'd15, 3'd7, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start; en_mask = tbl[i].mask; mif.out_ready = tbl[i].ready;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(mif.out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_ch", i),    32'(mif.out_ch),    32'(tbl[i].e_ch));
      chk($sformatf("tbl%0d_data", i),  32'(mif.out_data),  32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_sel", i),   32'(mif.sel),       32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),          32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i),  32'(sweep_done),    32'(tbl[i].e_done));
    end
    start = 1'b0;

    // Backpressure on the channel-2 sample
    en_mask = 8'hA5; mif.out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid_ch(3'd2, "bp_reach_ch2");
    mif.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(mif.out_valid), 32'd1);
      chk("bp_ch",    32'(mif.out_ch), 32'd2);
      chk("bp_data",  32'(mif.out_data), 32'd10);
      chk("bp_sel",   32'(mif.sel), 32'd2);
    end
    mif.out_ready = 1'b1;
    step();
    chk("bp_hs_valid", 32'(mif.out_valid), 32'd0);
    chk("bp_hs_sel",   32'(mif.sel), 32'd5);
    step();
    chk("bp_gap_valid", 32'(mif.out_valid), 32'd0);
    step();
    chk("bp_ch5_valid", 32'(mif.out_valid), 32'd1);
    chk("bp_ch5_ch",    32'(mif.out_ch), 32'd5);
    chk("bp_ch5_data",  32'(mif.out_data), 32'd13);
    wait_idle("bp_idle");

    // Continuous sweep, mask switched to 80 while ch1 is presented
    exp3 = '{1, 2, 99, 7, 99, 7, 99, 7, 99};
    ev.delete();
    en_mask = 8'h06; continuous = 1'b1; mif.out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; continuous = 1'b0;
    for (int cyc = 0; cyc < 60 && ev.size() < 9; cyc++) begin
      if (mif.out_valid && mif.out_ch == 3'd1) en_mask = 8'h80;
      pv = mif.out_valid; pch = mif.out_ch;
      step();
      if (pv) ev.push_back(32'(pch));
      if (sweep_done) ev.push_back(99);
    end
    chk("cont_events", 32'(ev.size()), 32'd9);
    for (int i = 0; i < ev.size() && i < 9; i++)
      chk($sformatf("cont_ev%0d", i), 32'(ev[i]), 32'(exp3[i]));
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("cont_stop_busy",  32'(busy), 32'd0);
    chk("cont_stop_valid", 32'(mif.out_valid), 32'd0);
    chk("cont_stop_done",  32'(sweep_done), 32'd0);

    // Ignored start with empty mask, ignored start during SETTLE
    en_mask = 8'h00; start = 1'b1;
    step();
    chk("zmask_busy", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    chk("zmask_busy2",  32'(busy), 32'd0);
    chk("zmask_valid",  32'(mif.out_valid), 32'd0);
    chk("zmask_done",   32'(sweep_done), 32'd0);
    en_mask = 8'hA5; start = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("restart_valid0", 32'(mif.out_valid), 32'd0);
    chk("restart_sel",    32'(mif.sel), 32'd0);
    step();
    chk("restart_valid1", 32'(mif.out_valid), 32'd1);
    chk("restart_ch",     32'(mif.out_ch), 32'd0);
    chk("restart_data",   32'(mif.out_data), 32'd8);
    step();
    chk("restart_next_sel", 32'(mif.sel), 32'd2);
    wait_idle("restart_idle");

    // Abort in HOLD with ready low, then a fresh start
    en_mask = 8'hA5; mif.out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid_ch(3'd2, "abort_reach_ch2");
    mif.out_ready = 1'b0;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("abort_valid", 32'(mif.out_valid), 32'd0);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_done",  32'(sweep_done), 32'd0);
    chk("abort_sel",   32'(mif.sel), 32'd2);
    chk("abort_data",  32'(mif.out_data), 32'd10);
    stop = 1'b1; start = 1'b1;
    step();
    chk("stop_start_busy", 32'(busy), 32'd0);
    stop = 1'b0;
    step();
    start = 1'b0;
    chk("fresh_sel",  32'(mif.sel), 32'd0);
    chk("fresh_busy", 32'(busy), 32'd1);
    mif.out_ready = 1'b1;
    wait_valid_ch(3'd0, "fresh_ch0");
    wait_idle("fresh_idle");

    // Asynchronous reset mid-SETTLE
    en_mask = 8'hA5; start = 1'b1;
    step();
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_sel",   32'(mif.sel), 32'd0);
    chk("arst_data",  32'(mif.out_data), 32'd0);
    chk("arst_ch",    32'(mif.out_ch), 32'd0);
    chk("arst_valid", 32'(mif.out_valid), 32'd0);
    chk("arst_done",  32'(sweep_done), 32'd0);
    #10;
    rst_n = 1'b1;
    step();
    en_mask = 8'h24; start = 1'b1;
    step();
    start = 1'b0;
    chk("arst_restart_sel", 32'(mif.sel), 32'd2);
    step();
    step();
    chk("arst_restart_valid", 32'(mif.out_valid), 32'd1);
    chk("arst_restart_ch",    32'(mif.out_ch), 32'd2);
    chk("arst_restart_data",  32'(mif.out_data), 32'd10);
    wait_idle("arst_idle");

    // Randomized sweeps against an expected-sample queue
    for (int run = 0; run < 40; run++) begin
      m = 8'($urandom_range(1, 255));
      c = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) lut[3'(k)] = 4'($urandom);
      q_ch.delete(); q_last.delete();
      for (int s = 0; s < (c ? 2 : 1); s++) begin
        for (int k = 0; k < 8; k++) begin
          if (m[k]) begin
            q_ch.push_back(3'(k));
            q_last.push_back(1'b0);
          end
        end
        q_last[q_last.size() - 1] = 1'b1;
      end
      en_mask = m; continuous = c; start = 1'b1;
      step();
      start = 1'b0;
      chk("rnd_busy_start", 32'(busy), 32'd1);
      since = 0; pv = mif.out_valid; budget = 0;
      while (q_ch.size() > 0 && budget < 400) begin
        rdy = ($urandom_range(0, 3) != 0);
        mif.out_ready = rdy;
        if (!c) en_mask = 8'($urandom);
        pch = mif.out_ch; pdata = mif.out_data;
        step();
        budget++; since++;
        if (pv && rdy) begin
          chk("rnd_done_hs", 32'(sweep_done), 32'(q_last[0]));
          chk("rnd_valid_drop", 32'(mif.out_valid), 32'd0);
          void'(q_ch.pop_front());
          void'(q_last.pop_front());
          since = 0;
        end else begin
          chk("rnd_done_idle", 32'(sweep_done), 32'd0);
          if (pv) begin
            chk("rnd_hold_valid", 32'(mif.out_valid), 32'd1);
            chk("rnd_hold_ch",    32'(mif.out_ch), 32'(pch));
            chk("rnd_hold_data",  32'(mif.out_data), 32'(pdata));
          end else if (mif.out_valid) begin
            chk("rnd_latency", 32'(since), 32'(DWELL));
            chk("rnd_ch",      32'(mif.out_ch), 32'(q_ch[0]));
            chk("rnd_data",    32'(mif.out_data), 32'(lut[q_ch[0]]));
          end
        end
        pv = mif.out_valid;
      end
      chk("rnd_timeout", 32'(q_ch.size()), 32'd0);
      if (c) begin
        chk("rnd_wrap_busy", 32'(busy), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("rnd_stop_valid", 32'(mif.out_valid), 32'd0);
      end
      chk("rnd_end_busy", 32'(busy), 32'd0);
      continuous = 1'b0;
      en_mask = 8'h00;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
